pc: RTL and testbench

- Program counter for the 16-bit core.
- Holds the current instruction address and presents it on `out`.
- Each clock it either increments by one, branches PC-relative by an immediate, or jumps absolute to a register value.
- Sits between decode (supplies imm, rs, select lines) and instruction fetch (consumes `out`).

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_next.sv | 26 ++
 rtl/pc.sv | 52 +++++
 tb/tb_pc.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared widths and select encodings for the program counter.
// Build option: define PC_STALL_EN to add a stall input to pc.
package pc_pkg;

  localparam int DATA_W       = 16;
  localparam int PC_IMR_SEL_W = 1;
  localparam int PC_BR_SEL_W  = 1;

  localparam logic PC_IMR_IMM = 1'b0;
  localparam logic PC_IMR_REG = 1'b1;
  localparam logic PC_BR_SEQ  = 1'b0;
  localparam logic PC_BR_TAKE = 1'b1;

endpackage

// File: rtl/pc_next.sv
// Combinational next-address selection: increment, PC-relative branch or absolute jump.
// Only bit 0 of each select is decoded; all arithmetic wraps modulo 2^DATA_W.
module pc_next
  import pc_pkg::*;
(
  input  logic [DATA_W-1:0]       pc_i,
  input  logic [DATA_W-1:0]       imm_i,
  input  logic [DATA_W-1:0]       rs_i,
  input  logic [PC_IMR_SEL_W-1:0] imr_sel_i,
  input  logic [PC_BR_SEL_W-1:0]  br_sel_i,
  output logic [DATA_W-1:0]       next_pc_o
);

  // Unselected operands are never read, so X on imm/rs cannot leak into the result.
  always_comb begin
    next_pc_o = pc_i + DATA_W'(1);
    if (br_sel_i[0] == PC_BR_TAKE) begin
      if (imr_sel_i[0] == PC_IMR_REG) begin
        next_pc_o = rs_i;
      end else begin
        next_pc_o = pc_i + imm_i;
      end
    end
  end

endmodule

// File: rtl/pc.sv
// Program counter register with synchronous active-high reset.
// Build option: PC_STALL_EN adds a stall input that holds the PC and drops branches.
module pc
  import pc_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       imm,
  input  logic [DATA_W-1:0]       rs,
  input  logic [PC_IMR_SEL_W-1:0] imr_sel,
  input  logic [PC_BR_SEL_W-1:0]  br_sel,
`ifdef PC_STALL_EN
  input  logic                    stall,
`endif
  output logic [DATA_W-1:0]       out
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] next_pc;

  pc_next u_pc_next (
    .pc_i      (pc_q),
    .imm_i     (imm),
    .rs_i      (rs),
    .imr_sel_i (imr_sel),
    .br_sel_i  (br_sel),
    .next_pc_o (next_pc)
  );

  always_comb begin
    pc_d = next_pc;
`ifdef PC_STALL_EN
    if (stall) begin
      pc_d = pc_q;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign out = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for pc: reset, increment, relative/absolute branches, wrap.
// Stall scenarios are exercised when built with PC_STALL_EN.
module tb_pc;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] imm;
  logic [15:0] rs;
  logic [0:0]  imr_sel;
  logic [0:0]  br_sel;
`ifdef PC_STALL_EN
  logic        stall;
`endif
  logic [15:0] out;

  int checks   = 0;
  int failures = 0;

  pc dut (
    .clock   (clock),
    .rst     (rst),
    .imm     (imm),
    .rs      (rs),
    .imr_sel (imr_sel),
    .br_sel  (br_sel),
`ifdef PC_STALL_EN
    .stall   (stall),
`endif
    .out     (out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (out === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, out, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_pc;

    rst = 1'b1; imm = 16'h0000; rs = 16'h0000; imr_sel = 1'b0; br_sel = 1'b0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    #2;
    tick();
    chk("reset", 16'h0000);

    // Count 1..100 from reset
    rst = 1'b0;
    exp_pc = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      tick();
      exp_pc = exp_pc + 16'h1;
      chk("count", exp_pc);
    end
    chk("count_100", 16'd100);

    // Sequential mode ignores imr_sel/rs
    imr_sel = 1'b1; rs = 16'h1234;
    for (int i = 0; i < 100; i++) begin
      tick();
      exp_pc = exp_pc + 16'h1;
      chk("seq_ignores_rs", exp_pc);
    end
    chk("at_c8", 16'h00C8);

    // Relative forward
    imm = 16'h0080; br_sel = 1'b1; imr_sel = 1'b0;
    tick();
    chk("rel_fwd", 16'h0148);
    br_sel = 1'b0;
    repeat (10) tick();
    chk("rel_fwd_then_10", 16'h0152);

    // Relative backward
    imm = 16'hFFF0; br_sel = 1'b1;
    tick();
    chk("rel_back", 16'h0142);
    br_sel = 1'b0;
    tick();
    chk("rel_back_resume", 16'h0143);

    // Held relative branch repeats every cycle
    imm = 16'h0002; br_sel = 1'b1;
    tick();
    chk("rel_hold_1", 16'h0145);
    tick();
    chk("rel_hold_2", 16'h0147);

    // Unselected X operands must not disturb increment
    imm = 'x; rs = 'x; br_sel = 1'b0;
    tick();
    chk("x_unused", 16'h0148);

    // Relative wrap below zero from a small PC
    rst = 1'b1; tick(); rst = 1'b0;
    chk("reset_again", 16'h0000);
    imm = 16'hFFF0; br_sel = 1'b1; imr_sel = 1'b0;
    tick();
    chk("rel_wrap_neg", 16'hFFF0);

    // Absolute jumps and wrap
    rs = 16'h8000; imr_sel = 1'b1; br_sel = 1'b1; imm = 16'h0005;
    tick();
    chk("abs_8000", 16'h8000);
    rs = 16'h1111;
    tick();
    chk("abs_hold_reload", 16'h1111);
    rs = 16'hFFFF;
    tick();
    chk("abs_ffff", 16'hFFFF);
    br_sel = 1'b0;
    tick();
    chk("wrap_to_0", 16'h0000);
    tick();
    chk("after_wrap", 16'h0001);

    // Mid-count reset discards a pending jump
    rs = 16'h4000; br_sel = 1'b1; imr_sel = 1'b1; rst = 1'b1;
    tick();
    chk("rst_over_branch", 16'h0000);
    rst = 1'b0; br_sel = 1'b0;
    tick();
    chk("restart_1", 16'h0001);
    tick();
    chk("restart_2", 16'h0002);

`ifdef PC_STALL_EN
    stall = 1'b1; br_sel = 1'b1; imr_sel = 1'b1; rs = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 16'h0002);
    end
    stall = 1'b0;
    tick();
    chk("stall_release_jump", 16'h4000);
    stall = 1'b1; rst = 1'b1;
    tick();
    chk("rst_over_stall", 16'h0000);
    rst = 1'b0; stall = 1'b0; br_sel = 1'b0;
    tick();
    chk("stall_restart", 16'h0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
